branch_predictor: RTL
=====================

// Module: branch_predictor
// PURPOSE
//   Fetch-stage dynamic branch predictor: direct-mapped BHT (2-bit saturating
//   counters) with a tagged BTB. Predicts direction/target for the IF PC.
//   Trained by the EX-stage branch condition result; flags mispredicts and
//   supplies the redirect PC to the PC-select logic.
// PARAMETERS
//   ENTRIES  32  table entries; power of 2, >= 2
//   IDX_W    $clog2(ENTRIES)  index width (derived, not overridden)
// PORTS
//   clk              in   1   clock, rising edge
//   rst_n            in   1   asynchronous active-low reset
//   if_pc            in   32  PC being fetched
//   pred_taken       out  1   predicted taken for if_pc
//   pred_target      out  32  BTB target (valid only when pred_taken=1)
//   next_pc          out  32  pred_taken ? pred_target : if_pc+4
//   ex_valid         in   1   conditional branch resolved in EX this cycle
//   ex_stall         in   1   EX held; blocks training and mispredict
//   ex_pc            in   32  PC of the resolved branch
//   ex_taken         in   1   condition result from EX branch unit
//   ex_target        in   32  computed branch target
//   ex_pred_taken    in   1   prediction carried down the pipe with the branch
//   ex_pred_target   in   32  predicted target carried down the pipe
//   mispredict       out  1   flush IF/ID and redirect fetch
//   redirect_pc      out  32  ex_taken ? ex_target : ex_pc+4
// BEHAVIOUR
//   - idx = pc[IDX_W+1:2]; tag = pc[31:IDX_W+2]; pc[1:0] ignored.
//   - Per entry: valid, tag, target[31:0], ctr[1:0].
//   - Lookup (combinational): hit = valid[idx] & tag match;
//     pred_taken = hit & ctr[1]; pred_target = target[idx].
//   - upd = ex_valid & ~ex_stall. Training commits on the clk edge when upd=1:
//       hit & ex_taken : ctr = min(ctr+1, 3); target <= ex_target
//       hit & ~ex_taken: ctr = max(ctr-1, 0); target unchanged
//       miss & ex_taken: allocate/replace: valid=1, tag, target, ctr=2'b10
//       miss & ~ex_taken: no change
//   - Same-cycle lookup and update of the same idx: lookup returns the
//     pre-update contents; the new contents are visible next cycle.
//   - mispredict = upd & ((ex_taken != ex_pred_taken) |
//                  (ex_taken & ex_pred_taken & ex_target != ex_pred_target)).
//     Combinational, 0-cycle latency; redirect_pc is always driven.
//   - 32-bit adds wrap modulo 2^32 (0xFFFFFFFC+4 = 0x00000000).
//   - Reset (async assert, any cycle, including mid-update): all valid = 0,
//     ctr = 2'b01, target/tag = 0. While rst_n = 0: pred_taken = 0,
//     next_pc = if_pc+4, mispredict = 0. Any update in flight is dropped.
// CONFIGURATION
//   BRANCH_PRED_STATS_EN defined: adds output ports br_count[31:0] and
//     mispred_count[31:0], both reset to 0. br_count +1 per upd cycle;
//     mispred_count +1 per mispredict cycle; both wrap at 2^32.
//   Not defined: these ports and counters do not exist; all other behaviour
//     is identical.
// TESTING (ENTRIES=32)
//   1 Reset, if_pc=0x100 -> pred_taken=0, next_pc=0x104; after release still 0.
//   2 upd: ex_pc=0x100, ex_taken=1, ex_target=0x80, ex_pred_taken=0 ->
//     mispredict=1, redirect_pc=0x80; next cycle if_pc=0x100 -> pred_taken=1,
//     next_pc=0x80.
//   3 Train 0x100 taken x3 (ctr=3), then not-taken x1 -> still pred_taken=1;
//     second not-taken -> pred_taken=0; a not-taken predicted not-taken ->
//     mispredict=0, redirect_pc=0x104.
//   4 Alias: 0x100 trained taken, lookup 0x180 (same idx) -> pred_taken=0;
//     taken update at 0x180 -> 0x180 hits, 0x100 misses.
//   5 upd at 0x100 and if_pc=0x100 same cycle -> old prediction that cycle,
//     new next cycle; ex_stall=1 with ex_valid=1 -> no training, mispredict=0.
//   6 rst_n low mid-training, then high -> all lookups miss; with
//     BRANCH_PRED_STATS_EN: 5 upd incl. 2 mispredicts -> br_count=5,
//     mispred_count=2.

Source files
------------

// File: rtl/branch_predictor.sv
// Fetch-stage branch predictor: direct-mapped 2-bit BHT with a tagged BTB, trained from EX.
// Optional BRANCH_PRED_STATS_EN adds br_count / mispred_count event counters.
module branch_predictor #(
  parameter  int ENTRIES = 32,
  localparam int IDX_W   = $clog2(ENTRIES)
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] if_pc,
  output logic        pred_taken,
  output logic [31:0] pred_target,
  output logic [31:0] next_pc,
  input  logic        ex_valid,
  input  logic        ex_stall,
  input  logic [31:0] ex_pc,
  input  logic        ex_taken,
  input  logic [31:0] ex_target,
  input  logic        ex_pred_taken,
  input  logic [31:0] ex_pred_target,
  output logic        mispredict,
`ifdef BRANCH_PRED_STATS_EN
  output logic [31:0] br_count,
  output logic [31:0] mispred_count,
`endif
  output logic [31:0] redirect_pc
);

  localparam int TAG_W = 30 - IDX_W;

  logic [ENTRIES-1:0] r_valid;
  logic [TAG_W-1:0]   r_tag    [ENTRIES];
  logic [31:0]        r_target [ENTRIES];
  logic [1:0]         r_ctr    [ENTRIES];

  logic [IDX_W-1:0] w_ifIdx;
  logic [TAG_W-1:0] w_ifTag;
  logic             w_ifHit;
  logic [IDX_W-1:0] w_exIdx;
  logic [TAG_W-1:0] w_exTag;
  logic             w_exHit;
  logic             w_upd;

  assign w_ifIdx = if_pc[IDX_W+1:2];
  assign w_ifTag = if_pc[31:IDX_W+2];
  assign w_ifHit = r_valid[w_ifIdx] && (r_tag[w_ifIdx] == w_ifTag);

  assign w_exIdx = ex_pc[IDX_W+1:2];
  assign w_exTag = ex_pc[31:IDX_W+2];
  assign w_exHit = r_valid[w_exIdx] && (r_tag[w_exIdx] == w_exTag);

  // Gating with rst_n keeps outputs quiet for the whole reset window.
  assign w_upd = rst_n & ex_valid & ~ex_stall;

  assign pred_taken  = rst_n & w_ifHit & r_ctr[w_ifIdx][1];
  assign pred_target = r_target[w_ifIdx];
  assign next_pc     = pred_taken ? pred_target : (if_pc + 32'd4);

  assign mispredict  = w_upd & ((ex_taken != ex_pred_taken) |
                       (ex_taken & ex_pred_taken & (ex_target != ex_pred_target)));
  assign redirect_pc = ex_taken ? ex_target : (ex_pc + 32'd4);

  // Table training; lookups see the old contents until the edge commits.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_valid <= '0;
      for (int i = 0; i < ENTRIES; i++) begin
        r_tag[i]    <= '0;
        r_target[i] <= '0;
        r_ctr[i]    <= 2'b01;
      end
    end else if (w_upd) begin
      if (w_exHit) begin
        if (ex_taken) begin
          r_target[w_exIdx] <= ex_target;
          if (r_ctr[w_exIdx] != 2'b11)
            r_ctr[w_exIdx] <= r_ctr[w_exIdx] + 2'd1;
        end else if (r_ctr[w_exIdx] != 2'b00) begin
          r_ctr[w_exIdx] <= r_ctr[w_exIdx] - 2'd1;
        end
      end else if (ex_taken) begin
        r_valid[w_exIdx]  <= 1'b1;
        r_tag[w_exIdx]    <= w_exTag;
        r_target[w_exIdx] <= ex_target;
        r_ctr[w_exIdx]    <= 2'b10;
      end
    end
  end

`ifdef BRANCH_PRED_STATS_EN
  logic [31:0] r_brCount;
  logic [31:0] r_mispredCount;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_brCount      <= '0;
      r_mispredCount <= '0;
    end else begin
      if (w_upd)
        r_brCount <= r_brCount + 32'd1;
      if (mispredict)
        r_mispredCount <= r_mispredCount + 32'd1;
    end
  end

  assign br_count      = r_brCount;
  assign mispred_count = r_mispredCount;
`endif

endmodule
